// File: rtl/edsac_tank_pkg.sv
// Shared timing constants and pointer arithmetic for the r2 store tanks
// and the r2 tank decoder.
package edsac_tank_pkg;

  localparam int WORD_BITS = 18;
  localparam int WORDS     = 32;
  localparam int TANK_BITS = WORD_BITS * WORDS;
  localparam int POS_W     = 5;
  localparam int PTR_W     = $clog2(TANK_BITS);

  // Flat cell index of (word_pos, bit_pos); the maximum is TANK_BITS-1.
  function automatic logic [PTR_W-1:0] tank_ptr(input logic [POS_W-1:0] word_pos,
                                                 input logic [POS_W-1:0] bit_pos);
    logic [PTR_W-1:0] w;
    logic [PTR_W-1:0] b;
    w = PTR_W'(word_pos);
    b = PTR_W'(bit_pos);
    return w * PTR_W'(WORD_BITS) + b;
  endfunction

endpackage

// File: rtl/tank_store_r2_if.sv
// Serial link between the r2 tank decoder (master) and one long tank store (slave).
interface tank_store_r2_if;

  logic                               dig_en;
  logic                               dec_in;
  logic                               clr;
  logic                               mib;
  logic                               mob;
  logic [edsac_tank_pkg::POS_W-1:0]   bit_pos;
  logic [edsac_tank_pkg::POS_W-1:0]   word_pos;
  logic                               word_sync;
  logic                               circ_sync;

  modport master (
    output dig_en, dec_in, clr, mib,
    input  mob, bit_pos, word_pos, word_sync, circ_sync
  );

  modport slave (
    input  dig_en, dec_in, clr, mib,
    output mob, bit_pos, word_pos, word_sync, circ_sync
  );

endinterface

// File: rtl/tank_pos_counter.sv
// Digit/minor-cycle position counters for a mercury tank circulation,
// with the word and circulation sync decodes of the current position.
module tank_pos_counter
  import edsac_tank_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [POS_W-1:0] bit_pos,
  output logic [POS_W-1:0] word_pos,
  output logic             word_sync,
  output logic             circ_sync
);

  logic [POS_W-1:0] bit_pos_reg;
  logic [POS_W-1:0] bit_pos_next;
  logic [POS_W-1:0] word_pos_reg;
  logic [POS_W-1:0] word_pos_next;

  always_comb begin
    bit_pos_next  = bit_pos_reg;
    word_pos_next = word_pos_reg;
    if (en) begin
      if (bit_pos_reg == POS_W'(WORD_BITS - 1)) begin
        bit_pos_next  = '0;
        word_pos_next = (word_pos_reg == POS_W'(WORDS - 1)) ? '0 : word_pos_reg + 1'b1;
      end else begin
        bit_pos_next = bit_pos_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_pos_reg  <= '0;
      word_pos_reg <= '0;
    end else begin
      bit_pos_reg  <= bit_pos_next;
      word_pos_reg <= word_pos_next;
    end
  end

  assign bit_pos   = bit_pos_reg;
  assign word_pos  = word_pos_reg;
  assign word_sync = (bit_pos_reg == '0);
  assign circ_sync = (bit_pos_reg == '0) && (word_pos_reg == '0);

endmodule

// File: rtl/tank_store_r2.sv
// One EDSAC long tank: a TANK_BITS ring of bit cells read and rewritten
// at the position pointer on every digit strobe.
module tank_store_r2
  import edsac_tank_pkg::*;
(
  input logic            clk,
  input logic            rst,
  tank_store_r2_if.slave bus
);

  logic [TANK_BITS-1:0] cells_reg;
  logic                 mob_reg;
  logic [PTR_W-1:0]     ptr;
  logic                 wr_bit;

  tank_pos_counter u_pos (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.dig_en),
    .bit_pos   (bus.bit_pos),
    .word_pos  (bus.word_pos),
    .word_sync (bus.word_sync),
    .circ_sync (bus.circ_sync)
  );

  assign ptr = tank_ptr(bus.word_pos, bus.bit_pos);

  // Clear wins over write, write wins over recirculation.
  always_comb begin
    wr_bit = cells_reg[ptr];
    if (bus.clr) begin
      wr_bit = 1'b0;
    end else if (bus.dec_in) begin
      wr_bit = bus.mib;
    end
  end

  // The whole tank clears on reset, so the cells live in flops rather than RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cells_reg <= '0;
      mob_reg   <= 1'b0;
    end else if (bus.dig_en) begin
      mob_reg        <= cells_reg[ptr];
      cells_reg[ptr] <= wr_bit;
    end
  end

  assign bus.mob = mob_reg;

endmodule

// File: tb/tb_tank_store_r2.sv
// Scoreboarded bench for one r2 long tank: recirculation, write, clear,
// strobe gaps and asynchronous reset.
module tb_tank_store_r2;
  import edsac_tank_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tank_store_r2_if bus ();

  tank_store_r2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic model_cells [TANK_BITS];
  int   exp_bit;
  int   exp_word;
  logic model_mob;
  logic exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < TANK_BITS; i++) model_cells[i] = 1'b0;
    exp_bit   = 0;
    exp_word  = 0;
    model_mob = 1'b0;
    exp_q.delete();
  endtask

  // One digit strobe; expected mob is queued at the strobe and compared after the edge.
  task automatic strobe(input logic d, input logic c, input logic m);
    int   p;
    logic exp_mob;
    p = exp_word * WORD_BITS + exp_bit;
    checks++;
    if (bus.bit_pos !== 5'(exp_bit)) begin
      errors++;
      $display("FAIL bit_pos got %0d expected %0d", bus.bit_pos, exp_bit);
    end
    checks++;
    if (bus.word_pos !== 5'(exp_word)) begin
      errors++;
      $display("FAIL word_pos got %0d expected %0d", bus.word_pos, exp_word);
    end
    checks++;
    if (bus.word_sync !== (exp_bit == 0)) begin
      errors++;
      $display("FAIL word_sync got %b at ptr %0d", bus.word_sync, p);
    end
    checks++;
    if (bus.circ_sync !== (exp_bit == 0 && exp_word == 0)) begin
      errors++;
      $display("FAIL circ_sync got %b at ptr %0d", bus.circ_sync, p);
    end
    bus.dig_en = 1'b1;
    bus.dec_in = d;
    bus.clr    = c;
    bus.mib    = m;
    exp_q.push_back(model_cells[p]);
    model_mob = model_cells[p];
    if (c) model_cells[p] = 1'b0;
    else if (d) model_cells[p] = m;
    @(posedge clk);
    #1;
    bus.dig_en = 1'b0;
    bus.dec_in = 1'b0;
    bus.clr    = 1'b0;
    bus.mib    = 1'b0;
    exp_mob = exp_q.pop_front();
    checks++;
    if (bus.mob !== exp_mob) begin
      errors++;
      $display("FAIL mob got %b expected %b at ptr %0d", bus.mob, exp_mob, p);
    end
    if (exp_bit == WORD_BITS - 1) begin
      exp_bit  = 0;
      exp_word = (exp_word == WORDS - 1) ? 0 : exp_word + 1;
    end else begin
      exp_bit = exp_bit + 1;
    end
  endtask

  task automatic advance_to(input int w, input int b);
    while (!(exp_word == w && exp_bit == b)) strobe(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bus.dig_en = 1'b0;
    bus.dec_in = 1'b0;
    bus.clr    = 1'b0;
    bus.mib    = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    checks++;
    if (bus.mob !== 1'b0 || bus.bit_pos !== 5'd0 || bus.word_pos !== 5'd0 ||
        bus.word_sync !== 1'b1 || bus.circ_sync !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got mob=%b bit=%0d word=%0d ws=%b cs=%b required 0 0 0 1 1",
               bus.mob, bus.bit_pos, bus.word_pos, bus.word_sync, bus.circ_sync);
    end
  endtask

  task automatic test_idle_circulation();
    int circ_cnt = 0;
    int word_cnt = 0;
    for (int i = 0; i <= TANK_BITS; i++) begin
      if (bus.circ_sync === 1'b1) circ_cnt++;
      if (bus.word_sync === 1'b1 && i < TANK_BITS) word_cnt++;
      strobe(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (circ_cnt !== 2) begin
      errors++;
      $display("FAIL circ_sync_count got %0d required 2", circ_cnt);
    end
    checks++;
    if (word_cnt !== WORDS) begin
      errors++;
      $display("FAIL word_sync_count got %0d required %0d", word_cnt, WORDS);
    end
  endtask

  task automatic test_write_word();
    logic [17:0] pat;
    logic [17:0] got;
    pat = 18'h2AAAA;
    advance_to(3, 0);
    for (int b = 0; b < WORD_BITS; b++) strobe(1'b1, 1'b0, pat[b]);
    advance_to(3, 0);
    for (int b = 0; b < WORD_BITS; b++) begin
      strobe(1'b0, 1'b0, 1'b0);
      got[b] = bus.mob;
    end
    checks++;
    if (got !== 18'h2AAAA) begin
      errors++;
      $display("FAIL write_word3 got %h required 2aaaa", got);
    end
  endtask

  task automatic test_clear_word();
    logic [17:0] w6;
    logic [17:0] w7;
    logic [17:0] w8;
    logic [4:0]  idx;
    advance_to(0, 0);
    for (int w = 0; w < WORDS; w++) begin
      idx = 5'(w);
      for (int b = 0; b < WORD_BITS; b++) strobe(1'b1, 1'b0, (b < 5) ? idx[b] : 1'b0);
    end
    advance_to(7, 0);
    for (int b = 0; b < WORD_BITS; b++) strobe(1'b0, 1'b1, 1'b0);
    advance_to(6, 0);
    for (int b = 0; b < WORD_BITS; b++) begin strobe(1'b0, 1'b0, 1'b0); w6[b] = bus.mob; end
    for (int b = 0; b < WORD_BITS; b++) begin strobe(1'b0, 1'b0, 1'b0); w7[b] = bus.mob; end
    for (int b = 0; b < WORD_BITS; b++) begin strobe(1'b0, 1'b0, 1'b0); w8[b] = bus.mob; end
    checks++;
    if (w6 !== 18'd6) begin errors++; $display("FAIL clear_word6 got %0d required 6", w6); end
    checks++;
    if (w7 !== 18'd0) begin errors++; $display("FAIL clear_word7 got %0d required 0", w7); end
    checks++;
    if (w8 !== 18'd8) begin errors++; $display("FAIL clear_word8 got %0d required 8", w8); end
  endtask

  task automatic test_clr_priority();
    advance_to(5, 10);
    strobe(1'b1, 1'b0, 1'b1);
    advance_to(5, 10);
    strobe(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.mob !== 1'b1) begin
      errors++;
      $display("FAIL cell100_write got %b required 1", bus.mob);
    end
    advance_to(5, 10);
    strobe(1'b1, 1'b1, 1'b1);
    advance_to(5, 10);
    strobe(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.mob !== 1'b0) begin
      errors++;
      $display("FAIL cell100_clr_priority got %b required 0", bus.mob);
    end
  endtask

  task automatic test_gap();
    advance_to(20, 9);
    for (int i = 0; i < 50; i++) begin
      bus.dig_en = 1'b0;
      bus.dec_in = 1'($urandom_range(1));
      bus.clr    = 1'($urandom_range(1));
      bus.mib    = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      checks++;
      if (bus.bit_pos !== 5'd9 || bus.word_pos !== 5'd20 || bus.mob !== model_mob) begin
        errors++;
        $display("FAIL gap_hold cycle %0d got bit=%0d word=%0d mob=%b required 9 20 %b",
                 i, bus.bit_pos, bus.word_pos, bus.mob, model_mob);
      end
    end
    bus.dec_in = 1'b0;
    bus.clr    = 1'b0;
    bus.mib    = 1'b0;
    for (int i = 0; i < TANK_BITS; i++) strobe(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    int ones = 0;
    advance_to(17, 5);
    checks++;
    if (bus.mob !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_mob got %b required 1", bus.mob);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.mob !== 1'b0 || bus.bit_pos !== 5'd0 || bus.word_pos !== 5'd0 || bus.circ_sync !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got mob=%b bit=%0d word=%0d cs=%b required 0 0 0 1",
               bus.mob, bus.bit_pos, bus.word_pos, bus.circ_sync);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < TANK_BITS; i++) begin
      strobe(1'b0, 1'b0, 1'b0);
      if (bus.mob === 1'b1) ones++;
    end
    checks++;
    if (ones !== 0) begin
      errors++;
      $display("FAIL post_reset_ones got %0d required 0", ones);
    end
  endtask

  initial begin
    test_reset();
    test_idle_circulation();
    test_write_word();
    test_clear_word();
    test_clr_priority();
    test_gap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
